// File: rtl/priority_encoder_8to3_seq.sv
// Registered 8-to-3 priority encoder with a sticky pending register, valid/ready
// serialisation of multi-hot requests, population count and a sticky overrun flag.
module priority_encoder_8to3_seq #(
  parameter int N  = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          Enable,
  input  logic [N-1:0]  D,
  input  logic          Ready,
  input  logic          clr_ovr,
  output logic [AW-1:0] A,
  output logic          Valid,
  output logic [AW:0]   Count,
  output logic          Overrun
);

  logic [N-1:0] pending;
  logic [N-1:0] req;
  logic [N-1:0] pop_mask;
  logic [N-1:0] pending_next;
  logic         pop;
  logic         ovr_hit;

  // Ascending scan: the last set bit seen is the highest, giving N-1 top priority.
  function automatic logic [AW-1:0] top_index(input logic [N-1:0] v);
    logic [AW-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) idx = AW'(i);
    end
    return idx;
  endfunction

  function automatic logic [AW:0] pop_count(input logic [N-1:0] v);
    logic [AW:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + {{AW{1'b0}}, v[i]};
    end
    return c;
  endfunction

  function automatic logic [N-1:0] one_hot(input logic [AW-1:0] idx);
    logic [N-1:0] m;
    m = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

  assign Valid    = |pending;
  assign A        = Valid ? top_index(pending) : '0;
  assign Count    = pop_count(pending);
  assign pop      = Valid & Ready;
  assign pop_mask = pop ? one_hot(A) : '0;
  assign req      = Enable ? D : '0;

  // A request on a bit being popped in the same cycle is a fresh request, not an overrun.
  assign ovr_hit      = |(req & pending & ~pop_mask);
  assign pending_next = (pending & ~pop_mask) | req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      Overrun <= 1'b0;
    end else begin
      pending <= pending_next;
      if (ovr_hit)
        Overrun <= 1'b1;
      else if (clr_ovr)
        Overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_priority_encoder_8to3_seq.sv
// Directed bench for priority_encoder_8to3_seq with an integer-mask reference model
// checked every cycle, plus literal expectations at the interesting points.
module tb_priority_encoder_8to3_seq;

  localparam int N  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          Enable = 1'b0;
  logic [N-1:0]  D = '0;
  logic          Ready = 1'b0;
  logic          clr_ovr = 1'b0;
  logic [AW-1:0] A;
  logic          Valid;
  logic [AW:0]   Count;
  logic          Overrun;

  int errors = 0;
  int checks = 0;

  int m_pend = 0;
  bit m_ovr  = 1'b0;

  priority_encoder_8to3_seq #(.N(N), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .Enable(Enable), .D(D), .Ready(Ready),
    .clr_ovr(clr_ovr), .A(A), .Valid(Valid), .Count(Count), .Overrun(Overrun)
  );

  always #5 clk = ~clk;

  function automatic int model_top(input int m);
    for (int i = N - 1; i >= 0; i--) begin
      if (((m >> i) & 1) != 0) return i;
    end
    return 0;
  endfunction

  function automatic int model_cnt(input int m);
    int c;
    c = 0;
    for (int i = 0; i < N; i++) c += (m >> i) & 1;
    return c;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the pending set as a plain integer bitmask.
  always @(posedge clk or negedge rst_n) begin : model
    int req;
    int pm;
    if (!rst_n) begin
      m_pend <= 0;
      m_ovr  <= 1'b0;
    end else begin
      req = Enable ? int'(D) : 0;
      pm  = (m_pend != 0 && Ready) ? (1 << model_top(m_pend)) : 0;
      if ((req & m_pend & ~pm) != 0) m_ovr <= 1'b1;
      else if (clr_ovr)              m_ovr <= 1'b0;
      m_pend <= ((m_pend & ~pm) | req) & 'hFF;
    end
  end

  always @(negedge clk) begin
    check("model_valid",   int'(Valid),   (m_pend != 0) ? 1 : 0);
    check("model_a",       int'(A),       (m_pend != 0) ? model_top(m_pend) : 0);
    check("model_count",   int'(Count),   model_cnt(m_pend));
    check("model_overrun", int'(Overrun), int'(m_ovr));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input int v, input int a, input int c);
    check({name, "_valid"}, int'(Valid), v);
    check({name, "_a"},     int'(A),     a);
    check({name, "_count"}, int'(Count), c);
  endtask

  int exp_a[4] = '{7, 5, 2, 0};
  int exp_c[4] = '{4, 3, 2, 1};

  initial begin
    repeat (2) step();
    expect_out("reset", 0, 0, 0);
    check("reset_ovr", int'(Overrun), 0);
    rst_n = 1'b1;
    step();

    // Single request, held while Ready=0
    Enable = 1'b1; D = 8'b0000_0010;
    step();
    Enable = 1'b0; D = '0;
    expect_out("single", 1, 1, 1);
    repeat (2) step();
    expect_out("single_hold", 1, 1, 1);
    Ready = 1'b1;
    step();
    Ready = 1'b0;
    expect_out("single_pop", 0, 0, 0);

    // Multi-hot serialised in priority order
    Enable = 1'b1; D = 8'b1010_0101;
    step();
    Enable = 1'b0; D = '0; Ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expect_out($sformatf("drain%0d", i), 1, exp_a[i], exp_c[i]);
      step();
    end
    expect_out("drain_empty", 0, 0, 0);
    Ready = 1'b0;

    // Higher-priority arrival pre-empts the presented index
    Enable = 1'b1; D = 8'b0000_1000;
    step();
    expect_out("preempt_lo", 1, 3, 1);
    D = 8'b0100_0000;
    step();
    Enable = 1'b0; D = '0;
    expect_out("preempt_hi", 1, 6, 2);
    Ready = 1'b1;
    step();
    expect_out("preempt_pop", 1, 3, 1);
    step();
    expect_out("preempt_empty", 0, 0, 0);
    Ready = 1'b0;

    // Overrun set, sticky, cleared
    Enable = 1'b1; D = 8'b0001_0000;
    step();
    check("ovr_first", int'(Overrun), 0);
    step();
    Enable = 1'b0; D = '0;
    check("ovr_set", int'(Overrun), 1);
    step();
    check("ovr_sticky", int'(Overrun), 1);
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    check("ovr_clr", int'(Overrun), 0);
    expect_out("ovr_pend", 1, 4, 1);

    // Pop and re-request of the same bit: stays pending, no overrun
    Ready = 1'b1; Enable = 1'b1; D = 8'b0001_0000;
    step();
    Enable = 1'b0; D = '0;
    expect_out("repop", 1, 4, 1);
    check("repop_ovr", int'(Overrun), 0);
    step();
    expect_out("repop_empty", 0, 0, 0);
    Ready = 1'b0;

    // Set wins over a simultaneous clear
    Enable = 1'b1; D = 8'b0000_0001;
    step();
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0; Enable = 1'b0; D = '0;
    check("ovr_set_wins", int'(Overrun), 1);
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    check("ovr_clr2", int'(Overrun), 0);
    Ready = 1'b1;
    step();
    Ready = 1'b0;

    // All ones, Count=8 without wrap, then async reset mid-drain
    Enable = 1'b1; D = 8'hFF;
    step();
    Enable = 1'b0; D = '0;
    expect_out("full", 1, 7, 8);
    Ready = 1'b1;
    step();
    expect_out("full_pop1", 1, 6, 7);
    step();
    expect_out("full_pop2", 1, 5, 6);
    rst_n = 1'b0;
    #1;
    expect_out("async_rst", 0, 0, 0);
    check("async_rst_ovr", int'(Overrun), 0);
    step();
    rst_n = 1'b1;
    step();
    expect_out("post_rst", 0, 0, 0);
    Ready = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
